// File: rtl/otter_intr_ctrl.sv
// Multi-source interrupt controller for the OTTER core's single INTR input.
// Synchronised rising edges latch into PENDING, are masked by ENABLE, and are claimed lowest-index first.
module otter_intr_ctrl #(
    parameter int unsigned N_SRC       = 8,
    parameter logic [31:0] BASE_ADDR   = 32'h1100_0100,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             RST,
    input  logic [N_SRC-1:0] irq_src,
    input  logic [31:0]      IOBUS_ADDR,
    input  logic [31:0]      IOBUS_OUT,
    input  logic             IOBUS_WR,
    input  logic             int_taken,
    input  logic             mret_exec,
    output logic             INTR,
    output logic [31:0]      io_rdata,
    output logic             io_hit
);

    localparam int unsigned ID_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [N_SRC-1:0]  sync_q [SYNC_STAGES];
    logic [N_SRC-1:0]  sync_prev_q;
    logic [N_SRC-1:0]  enable_q, enable_d;
    logic [N_SRC-1:0]  pending_q, pending_d;
    logic [N_SRC-1:0]  edge_c, active_c, claim_mask_c;
    logic [ID_W-1:0]   claim_id_q, claim_id_d, claim_sel_c;
    logic              in_service_c;
    logic              reg_sel_c, wr_enable_c, wr_pending_c, wr_claim_c;
    logic              unused_wdata;

    // Register decode: the whole 16-byte window hits, only word-aligned offsets map
    assign io_hit       = (IOBUS_ADDR[31:4] == BASE_ADDR[31:4]);
    assign reg_sel_c    = io_hit && (IOBUS_ADDR[1:0] == 2'b00);
    assign wr_enable_c  = IOBUS_WR && reg_sel_c && (IOBUS_ADDR[3:2] == 2'd0);
    assign wr_pending_c = IOBUS_WR && reg_sel_c && (IOBUS_ADDR[3:2] == 2'd1);
    assign wr_claim_c   = IOBUS_WR && reg_sel_c && (IOBUS_ADDR[3:2] == 2'd2);
    assign unused_wdata = ^IOBUS_OUT[31:N_SRC];

    assign in_service_c = (state_q == ST_SERVICE);

    always_comb begin
        io_rdata = '0;
        if (reg_sel_c) begin
            case (IOBUS_ADDR[3:2])
                2'd0:    io_rdata = 32'(enable_q);
                2'd1:    io_rdata = 32'(pending_q);
                2'd2:    io_rdata = {in_service_c, 26'b0, claim_id_q};
                default: io_rdata = {30'b0, state_q};
            endcase
        end
    end

    // Source synchronisers plus one flop of edge history
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            sync_prev_q <= '0;
        end else begin
            sync_q[0] <= irq_src;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            sync_prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign edge_c   = sync_q[SYNC_STAGES-1] & ~sync_prev_q;
    assign active_c = pending_q & enable_q;

    // Lowest active index wins the claim
    always_comb begin
        claim_sel_c = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (active_c[i]) claim_sel_c = ID_W'(i);
        end
    end

    assign claim_mask_c = active_c & (~active_c + N_SRC'(1));

    always_comb begin
        state_d    = state_q;
        enable_d   = enable_q;
        pending_d  = pending_q;
        claim_id_d = claim_id_q;
        if (wr_enable_c)  enable_d  = IOBUS_OUT[N_SRC-1:0];
        if (wr_pending_c) pending_d = pending_d & ~IOBUS_OUT[N_SRC-1:0];
        case (state_q)
            ST_IDLE: begin
                if (|active_c) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (!(|active_c)) begin
                    state_d = ST_IDLE;
                end else if (int_taken) begin
                    claim_id_d = claim_sel_c;
                    pending_d  = pending_d & ~claim_mask_c;
                    state_d    = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                if (mret_exec || wr_claim_c) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // A fresh edge beats a same-cycle clear
        pending_d = pending_d | edge_c;
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            enable_q   <= '0;
            pending_q  <= '0;
            claim_id_q <= '0;
            INTR       <= 1'b0;
        end else begin
            state_q    <= state_d;
            enable_q   <= enable_d;
            pending_q  <= pending_d;
            claim_id_q <= claim_id_d;
            INTR       <= (state_d == ST_REQ);
        end
    end

endmodule

// File: tb/tb_otter_intr_ctrl.sv
// Self-checking bench for otter_intr_ctrl: decode table, directed corner sequences,
// then randomized traffic compared against a cycle-level behavioural model.
module tb_otter_intr_ctrl;

    localparam int unsigned N    = 8;
    localparam int unsigned S    = 2;
    localparam logic [31:0] BASE = 32'h1100_0100;

    logic        clk = 1'b0;
    logic        RST;
    logic [7:0]  irq_src;
    logic [31:0] addr, wdata;
    logic        wr, int_taken, mret_exec;
    logic        INTR;
    logic [31:0] io_rdata;
    logic        io_hit;

    int n_cmp = 0;
    int n_bad = 0;

    otter_intr_ctrl #(.N_SRC(N), .BASE_ADDR(BASE), .SYNC_STAGES(S)) dut (
        .clk(clk), .RST(RST), .irq_src(irq_src),
        .IOBUS_ADDR(addr), .IOBUS_OUT(wdata), .IOBUS_WR(wr),
        .int_taken(int_taken), .mret_exec(mret_exec),
        .INTR(INTR), .io_rdata(io_rdata), .io_hit(io_hit)
    );

    always #5 clk = ~clk;

    // Behavioural model: mode 0/1/2 = idle/requesting/in service
    logic [7:0] m_en, m_pend;
    logic [7:0] m_smp [S+1];
    int         m_mode;
    logic [4:0] m_claim;
    logic       m_intr;

    task automatic model_reset();
        m_en = '0; m_pend = '0; m_mode = 0; m_claim = '0; m_intr = 1'b0;
        for (int j = 0; j <= S; j++) m_smp[j] = '0;
    endtask

    task automatic model_step();
        logic [7:0] edges, act, np;
        int         nm;
        bit         hit, found;
        logic [3:0] off;
        if (RST) begin
            model_reset();
        end else begin
            // m_smp[j] holds the source sample taken j+1 edges ago
            edges = m_smp[S-1] & ~m_smp[S];
            for (int j = S; j > 0; j--) m_smp[j] = m_smp[j-1];
            m_smp[0] = irq_src;
            hit = wr && (addr[31:4] == BASE[31:4]) && (addr[1:0] == 2'b00);
            off = addr[3:0];
            act = m_en & m_pend;
            np  = m_pend;
            nm  = m_mode;
            if (hit && off == 4'h0) m_en = wdata[7:0];
            if (hit && off == 4'h4) np = np & ~wdata[7:0];
            case (m_mode)
                0: if (act != 0) nm = 1;
                1: begin
                    if (act == 0) nm = 0;
                    else if (int_taken) begin
                        found = 0;
                        for (int i = 0; i < 8; i++) begin
                            if (act[i] && !found) begin
                                m_claim = 5'(i);
                                found   = 1;
                            end
                        end
                        np[m_claim] = 1'b0;
                        nm = 2;
                    end
                end
                default: if (mret_exec || (hit && off == 4'h8)) nm = 0;
            endcase
            m_pend = np | edges;
            m_mode = nm;
            m_intr = (nm == 1);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [3:0] off);
        case (off)
            4'h0:    return {24'b0, m_en};
            4'h4:    return {24'b0, m_pend};
            4'h8:    return {m_mode == 2, 26'b0, m_claim};
            default: return 32'(m_mode);
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic rd(input logic [3:0] off, output logic [31:0] v);
        addr = BASE + 32'(off);
        wr   = 1'b0;
        #1;
        v = io_rdata;
    endtask

    task automatic chk_reg(input string name, input logic [3:0] off, input logic [31:0] exp);
        logic [31:0] v;
        rd(off, v);
        chk(name, v, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr_reg(input logic [3:0] off, input logic [31:0] data);
        addr  = BASE + 32'(off);
        wdata = data;
        wr    = 1'b1;
        tick();
        wr    = 1'b0;
    endtask

    task automatic pulse_taken();
        int_taken = 1'b1; tick(); int_taken = 1'b0;
    endtask

    task automatic pulse_mret();
        mret_exec = 1'b1; tick(); mret_exec = 1'b0;
    endtask

    typedef struct {
        logic [31:0] a;
        logic        w;
        logic [31:0] d;
        logic        exp_hit;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl [11];

    initial begin
        logic [3:0] roff;

        tbl[0]  = '{BASE,              1'b1, 32'hFFFF_FF5A, 1'b1, 32'h0};
        tbl[1]  = '{BASE,              1'b0, 32'h0,         1'b1, 32'h0000_005A};
        tbl[2]  = '{BASE + 32'hC,      1'b0, 32'h0,         1'b1, 32'h0};
        tbl[3]  = '{BASE + 32'h8,      1'b0, 32'h0,         1'b1, 32'h0};
        tbl[4]  = '{BASE + 32'h4,      1'b0, 32'h0,         1'b1, 32'h0};
        tbl[5]  = '{BASE + 32'h10,     1'b0, 32'h0,         1'b0, 32'h0};
        tbl[6]  = '{BASE - 32'h4,      1'b0, 32'h0,         1'b0, 32'h0};
        tbl[7]  = '{BASE,              1'b1, 32'h0,         1'b1, 32'h0000_005A};
        tbl[8]  = '{BASE,              1'b0, 32'h0,         1'b1, 32'h0};
        tbl[9]  = '{32'h1100_0000,     1'b1, 32'h0000_00FF, 1'b0, 32'h0};
        tbl[10] = '{BASE,              1'b0, 32'h0,         1'b1, 32'h0};

        RST = 1'b1; irq_src = 8'hFF; addr = BASE; wdata = '0;
        wr = 1'b0; int_taken = 1'b0; mret_exec = 1'b0;
        model_reset();
        ticks(2);

        // Reset with all sources high
        chk("rst intr", 32'(INTR), 32'h0);
        chk_reg("rst enable", 4'h0, 32'h0);
        chk_reg("rst pending", 4'h4, 32'h0);
        chk_reg("rst claim", 4'h8, 32'h0);
        chk_reg("rst status", 4'hC, 32'h0);
        irq_src = 8'h00;
        tick();
        RST = 1'b0;
        ticks(4);
        chk_reg("post-rst pending", 4'h4, 32'h0);
        chk("post-rst intr", 32'(INTR), 32'h0);

        // Decode / register access table
        foreach (tbl[i]) begin
            addr = tbl[i].a; wdata = tbl[i].d; wr = tbl[i].w;
            #1;
            chk($sformatf("tbl%0d hit", i), 32'(io_hit), 32'(tbl[i].exp_hit));
            chk($sformatf("tbl%0d rdata", i), io_rdata, tbl[i].exp_rd);
            tick();
            wr = 1'b0;
        end

        // Single source through claim and mret
        wr_reg(4'h0, 32'h04);
        irq_src = 8'h04;
        ticks(2);
        chk_reg("t2 pend early", 4'h4, 32'h0);
        tick();
        chk_reg("t2 pend", 4'h4, 32'h04);
        chk("t2 intr early", 32'(INTR), 32'h0);
        tick();
        chk("t2 intr", 32'(INTR), 32'h1);
        chk_reg("t2 status req", 4'hC, 32'h1);
        irq_src = 8'h00;
        pulse_taken();
        chk_reg("t2 claim", 4'h8, 32'h8000_0002);
        chk_reg("t2 pend clr", 4'h4, 32'h0);
        chk("t2 intr off", 32'(INTR), 32'h0);
        chk_reg("t2 status svc", 4'hC, 32'h2);
        pulse_mret();
        chk_reg("t2 status idle", 4'hC, 32'h0);
        chk_reg("t2 claim kept", 4'h8, 32'h0000_0002);

        // Priority between simultaneous sources 1 and 5
        wr_reg(4'h0, 32'hFF);
        irq_src = 8'h22;
        ticks(3);
        chk_reg("t3 pend", 4'h4, 32'h22);
        tick();
        chk("t3 intr", 32'(INTR), 32'h1);
        pulse_taken();
        chk_reg("t3 claim1", 4'h8, 32'h8000_0001);
        chk_reg("t3 pend left", 4'h4, 32'h20);
        pulse_mret();
        chk_reg("t3 status idle", 4'hC, 32'h0);
        tick();
        chk("t3 intr again", 32'(INTR), 32'h1);
        pulse_taken();
        chk_reg("t3 claim2", 4'h8, 32'h8000_0005);
        chk_reg("t3 pend empty", 4'h4, 32'h0);
        pulse_mret();
        irq_src = 8'h00;
        ticks(3);

        // Masking
        wr_reg(4'h0, 32'h0);
        irq_src = 8'h08;
        ticks(4);
        chk_reg("t4 pend masked", 4'h4, 32'h08);
        chk("t4 intr masked", 32'(INTR), 32'h0);
        chk_reg("t4 status masked", 4'hC, 32'h0);
        wr_reg(4'h0, 32'h08);
        chk("t4 intr +1", 32'(INTR), 32'h0);
        tick();
        chk("t4 intr +2", 32'(INTR), 32'h1);
        wr_reg(4'h0, 32'h0);
        chk("t4 intr hold", 32'(INTR), 32'h1);
        tick();
        chk("t4 intr drop", 32'(INTR), 32'h0);
        chk_reg("t4 status drop", 4'hC, 32'h0);
        wr_reg(4'h4, 32'h08);
        chk_reg("t4 w1c", 4'h4, 32'h0);
        irq_src = 8'h00;
        ticks(3);

        // W1C colliding with a fresh edge
        irq_src = 8'h10;
        ticks(3);
        chk_reg("t5 pend", 4'h4, 32'h10);
        irq_src = 8'h00;
        ticks(3);
        irq_src = 8'h10;
        ticks(2);
        wr_reg(4'h4, 32'h10);
        chk_reg("t5 set wins", 4'h4, 32'h10);
        wr_reg(4'h4, 32'h10);
        chk_reg("t5 w1c plain", 4'h4, 32'h0);
        irq_src = 8'h00;
        ticks(3);

        // CLAIM write completes service; mret in IDLE is ignored
        wr_reg(4'h0, 32'h10);
        irq_src = 8'h10;
        ticks(4);
        chk("t5 intr", 32'(INTR), 32'h1);
        pulse_taken();
        chk_reg("t5 status svc", 4'hC, 32'h2);
        wr_reg(4'h8, 32'hDEAD_BEEF);
        chk_reg("t5 status cpl", 4'hC, 32'h0);
        chk_reg("t5 claim cpl", 4'h8, 32'h0000_0004);
        pulse_mret();
        chk_reg("t5 idle mret status", 4'hC, 32'h0);
        chk_reg("t5 idle mret claim", 4'h8, 32'h0000_0004);
        chk("t5 idle mret intr", 32'(INTR), 32'h0);
        irq_src = 8'h00;
        ticks(3);

        // No nesting while in service, then async reset mid-cycle
        wr_reg(4'h0, 32'h03);
        irq_src = 8'h01;
        ticks(4);
        pulse_taken();
        irq_src = 8'h03;
        ticks(4);
        chk_reg("t6 pend in svc", 4'h4, 32'h02);
        chk("t6 no nest", 32'(INTR), 32'h0);
        chk_reg("t6 status svc", 4'hC, 32'h2);
        #2;
        RST = 1'b1;
        model_reset();
        #1;
        chk("t6 rst intr", 32'(INTR), 32'h0);
        chk_reg("t6 rst enable", 4'h0, 32'h0);
        chk_reg("t6 rst pending", 4'h4, 32'h0);
        chk_reg("t6 rst claim", 4'h8, 32'h0);
        chk_reg("t6 rst status", 4'hC, 32'h0);
        @(negedge clk);
        irq_src = 8'h00;
        tick();
        RST = 1'b0;
        ticks(4);
        chk_reg("t6 idle after", 4'hC, 32'h0);
        chk("t6 intr after", 32'(INTR), 32'h0);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            roff = 4'($urandom_range(0, 3) * 4);
            addr = BASE + 32'(roff);
            wr   = 1'b0;
            #1;
            chk("rnd intr", 32'(INTR), 32'(m_intr));
            chk($sformatf("rnd reg%0h", roff), io_rdata, model_read(roff));
            RST       = ($urandom_range(0, 299) == 0);
            irq_src   = irq_src ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            int_taken = ($urandom_range(0, 2) == 0);
            mret_exec = ($urandom_range(0, 4) == 0);
            wr        = ($urandom_range(0, 7) == 0);
            wdata     = $urandom;
            case ($urandom_range(0, 5))
                4:       addr = BASE + 32'h10;
                5:       addr = BASE - 32'h10;
                default: addr = BASE + 32'($urandom_range(0, 3) * 4);
            endcase
            tick();
        end
        RST = 1'b0; wr = 1'b0; int_taken = 1'b0; mret_exec = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
